scariv_front_rcv_buf: RTL and testbench
=======================================

# scariv_front_rcv_buf

Slave-side receive buffer for the `scariv_front_if` protocol. It accepts `front_t` dispatch groups from the decode/instruction-buffer stage and re-presents them, in order, to the rename stage as a `scariv_front_if` master. The registered boundary breaks the combinational `ready` path from rename back into decode. It also supports pipeline flush and keeps a count of branch-bearing groups in flight.

## Interface
Parameters:
- `DEPTH`, default 2: number of buffered groups. Must be a power of two and ≥2.

Ports:
- `i_clk`  in  1  clock.
- `i_reset`  in  1  synchronous, active-high reset.
- `ibuf_front_if`  `scariv_front_if.slave`  —  upstream groups (`valid`, `payload`, `ready`).
- `rn_front_if`  `scariv_front_if.master`  —  downstream groups to rename.
- `i_flush_valid`  in  1  commit/branch flush: kill all buffered and incoming groups.
- `o_occupancy`  out  `$clog2(DEPTH)+1`  number of valid entries.
- `o_br_in_buf`  out  `$clog2(DEPTH)+1`  number of buffered entries with `is_br_included`=1.

## Operation
- Storage is a circular FIFO of `DEPTH` `front_t` entries, with read/write pointers carrying an extra wrap bit.
  - Empty: pointers are fully equal.
  - Full: indices are equal and wrap bits differ.
- Enqueue happens when `ibuf.valid & ibuf.ready & !i_flush_valid`. The payload is written at `wr_ptr`, then `wr_ptr` increments.
- `ibuf.ready` = `!full`, computed from registered state only. It is never a function of `rn.ready`, so there is no combinational path from input to output handshake.
- `rn.valid` = `!empty & !i_flush_valid`. `rn.payload` = the entry at `rd_ptr`.
- Dequeue happens when `rn.valid & rn.ready`; then `rd_ptr` increments.
- Simultaneous enqueue and dequeue: occupancy is unchanged. When full, no enqueue is allowed even if a dequeue occurs in the same cycle.
- Flush, in cycle N:
  - `rd_ptr` is set to `wr_ptr`, which empties the buffer.
  - Any incoming beat in cycle N is dropped, even though the handshake completes upstream.
  - `rn.valid` = 0 in cycle N.
  - `o_br_in_buf` becomes 0 at N+1.
- `o_br_in_buf` counter:
  - +1 on enqueue with `is_br_included`.
  - −1 on dequeue of an entry with `is_br_included`.
  - Both in the same cycle leave it unchanged.
  - Never underflows or overflows; the bench asserts this.
- Payload fields, including `int_inserted`, `tlb_except_*` and `cmt_id`, pass through bit-exact. No field is modified.
- Reset: pointers = 0, `o_occupancy` = 0, `o_br_in_buf` = 0, `rn.valid` = 0, `ibuf.ready` = 1 in the first cycle after reset. Payload RAM is not reset.
- Reset asserted mid-operation discards all contents at the next edge, identical to power-on.

## Timing
- Latency: a group enqueued at edge N is visible on `rn` in cycle N+1. There is no same-cycle bypass.
- Throughput: with `DEPTH` = 2 and `rn.ready` held at 1, one group per cycle is sustained, with steady-state occupancy 1.
- Output `rn.payload` comes straight from a register/RAM read. The only combinational input-to-output path is `i_flush_valid` → `rn.valid`.
- The `rn` payload must stay stable while `rn.valid & !rn.ready`. The bench asserts this.

## Structure
- No new package types are needed. `front_t` and `scariv_front_if` are reused unchanged.
- Pointer width `$clog2(DEPTH)+1` is a local parameter.
- Natural sub-module: `scariv_rcv_ptr`, a wrap-bit pointer with increment and load. Instantiate it twice, for read and write.
- The `is_br_included` per-entry bit may be derived from the stored payload, so no separate array is needed.

## Test plan
- Reset, then 8 back-to-back groups (`cmt_id` 0..7) with `rn.ready`=1 → output order 0..7, first at cycle+1, one per cycle, `ibuf.ready` constantly 1.
- `rn.ready`=0 with 3 groups offered → 2 accepted, `ibuf.ready`=0 and `o_occupancy`=2; `rn.ready`=1 → `ibuf.ready`=1 the next cycle and the third group is accepted.
- Full buffer plus same-cycle `rn.ready`=1 and `ibuf.valid`=1 → only the dequeue occurs; occupancy goes 2→1.
- 2 buffered groups with `is_br_included`=1, `i_flush_valid` pulsed while a third is offered → `rn.valid`=0 that cycle, `o_occupancy`=0, `o_br_in_buf`=0 next cycle, third group never appears.
- Pointer wrap: 100 random groups with random `rn.ready` → scoreboard matches all payloads bit-exact and in order; `o_br_in_buf` always equals the count from the reference model.
- `i_reset` asserted with 2 entries buffered → next cycle `rn.valid`=0, `o_occupancy`=0, `ibuf.ready`=1.

Source files
------------

// File: rtl/scariv_front_rcv_buf_pkg.sv
// Shared types for the front-end receive buffer: the dispatch group carried on scariv_front_if.
package scariv_front_rcv_buf_pkg;

   localparam int unsigned CMT_ID_W    = 6;
   localparam int unsigned TLB_CAUSE_W = 4;
   localparam int unsigned VADDR_W     = 32;
   localparam int unsigned INST_W      = 32;

   typedef struct packed {
      logic [CMT_ID_W-1:0]    cmt_id;
      logic                   is_br_included;
      logic                   int_inserted;
      logic                   tlb_except_valid;
      logic [TLB_CAUSE_W-1:0] tlb_except_cause;
      logic [VADDR_W-1:0]     pc_addr;
      logic [INST_W-1:0]      inst;
   } front_t;

endpackage

// File: rtl/scariv_front_if.sv
// Valid/ready handshake carrying one front_t dispatch group per beat.
interface scariv_front_if;
   import scariv_front_rcv_buf_pkg::*;

   logic   valid;
   front_t payload;
   logic   ready;

   modport master (output valid, output payload, input ready);
   modport slave  (input valid, input payload, output ready);

endinterface

// File: rtl/scariv_rcv_ptr.sv
// FIFO pointer with an extra wrap bit; supports increment and a higher-priority load.
module scariv_rcv_ptr #(
   parameter int unsigned PTR_W = 2
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_inc,
   input  logic             i_load,
   input  logic [PTR_W-1:0] i_load_val,
   output logic [PTR_W-1:0] o_ptr
);

   logic [PTR_W-1:0] ptr_q, ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (i_load) begin
         ptr_d = i_load_val;
      end else if (i_inc) begin
         ptr_d = ptr_q + PTR_W'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign o_ptr = ptr_q;

endmodule

// File: rtl/scariv_front_rcv_buf.sv
// Registered receive buffer between decode and rename: breaks the ready path, supports flush,
// and tracks how many buffered groups carry a branch.
module scariv_front_rcv_buf
   import scariv_front_rcv_buf_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   scariv_front_if.slave         ibuf_front_if,
   scariv_front_if.master        rn_front_if,
   input  logic                  i_flush_valid,
   output logic [$clog2(DEPTH):0] o_occupancy,
   output logic [$clog2(DEPTH):0] o_br_in_buf
);

   localparam int unsigned PTR_W = $clog2(DEPTH) + 1;
   localparam int unsigned IDX_W = $clog2(DEPTH);

   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             empty, full, enq, deq, enq_br, deq_br;
   front_t           ram_q [DEPTH];
   front_t           rd_entry;
   logic [PTR_W-1:0] br_cnt_q, br_cnt_d;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);

   // Ready depends only on registered state so rename's ready never reaches decode.
   assign ibuf_front_if.ready = !full;
   assign enq = ibuf_front_if.valid && !full && !i_flush_valid;

   assign rd_entry            = ram_q[rd_ptr[IDX_W-1:0]];
   assign rn_front_if.valid   = !empty && !i_flush_valid;
   assign rn_front_if.payload = rd_entry;
   assign deq = rn_front_if.valid && rn_front_if.ready;

   assign enq_br = enq && ibuf_front_if.payload.is_br_included;
   assign deq_br = deq && rd_entry.is_br_included;

   scariv_rcv_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_inc      (enq),
      .i_load     (1'b0),
      .i_load_val ('0),
      .o_ptr      (wr_ptr)
   );

   // Flush collapses the read pointer onto the write pointer, emptying the buffer.
   scariv_rcv_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_inc      (deq),
      .i_load     (i_flush_valid),
      .i_load_val (wr_ptr),
      .o_ptr      (rd_ptr)
   );

   always_ff @(posedge i_clk) begin
      if (enq) begin
         ram_q[wr_ptr[IDX_W-1:0]] <= ibuf_front_if.payload;
      end
   end

   always_comb begin
      br_cnt_d = br_cnt_q;
      if (i_flush_valid) begin
         br_cnt_d = '0;
      end else begin
         if (enq_br) br_cnt_d = br_cnt_d + PTR_W'(1);
         if (deq_br) br_cnt_d = br_cnt_d - PTR_W'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         br_cnt_q <= '0;
      end else begin
         br_cnt_q <= br_cnt_d;
      end
   end

   assign o_occupancy = wr_ptr - rd_ptr;
   assign o_br_in_buf = br_cnt_q;

endmodule

// File: tb/tb_scariv_front_rcv_buf.sv
// Bench for scariv_front_rcv_buf: directed scenarios plus a randomized run against a queue model.
module tb_scariv_front_rcv_buf;
   import scariv_front_rcv_buf_pkg::*;

   localparam int unsigned DEPTH = 2;
   localparam int unsigned OW    = $clog2(DEPTH) + 1;

   logic          clk   = 1'b0;
   logic          reset = 1'b1;
   logic          flush = 1'b0;
   logic [OW-1:0] occ, br;
   int            checks   = 0;
   int            failures = 0;

   scariv_front_if ibuf_if ();
   scariv_front_if rn_if ();

   scariv_front_rcv_buf #(.DEPTH(DEPTH)) u_dut (
      .i_clk         (clk),
      .i_reset       (reset),
      .ibuf_front_if (ibuf_if),
      .rn_front_if   (rn_if),
      .i_flush_valid (flush),
      .o_occupancy   (occ),
      .o_br_in_buf   (br)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic front_t rand_front(input int id, input logic br_bit);
      front_t f;
      f.cmt_id           = CMT_ID_W'(id);
      f.is_br_included   = br_bit;
      f.int_inserted     = 1'($urandom);
      f.tlb_except_valid = 1'($urandom);
      f.tlb_except_cause = TLB_CAUSE_W'($urandom);
      f.pc_addr          = $urandom;
      f.inst             = $urandom;
      return f;
   endfunction

   function automatic int br_count(input front_t qq[$]);
      int n = 0;
      foreach (qq[i]) if (qq[i].is_br_included) n++;
      return n;
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      ibuf_if.valid   = 1'b0;
      ibuf_if.payload = '0;
      rn_if.ready     = 1'b0;
      flush           = 1'b0;
      reset           = 1'b1;
      next_cycle();
      next_cycle();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks++;
      if (rn_if.valid !== 1'b0) begin
         failures++; $display("FAIL reset_rn_valid: got %b want 0", rn_if.valid);
      end
      checks++;
      if (ibuf_if.ready !== 1'b1) begin
         failures++; $display("FAIL reset_ibuf_ready: got %b want 1", ibuf_if.ready);
      end
      checks++;
      if (occ !== OW'(0)) begin
         failures++; $display("FAIL reset_occupancy: got %0d want 0", occ);
      end
      checks++;
      if (br !== OW'(0)) begin
         failures++; $display("FAIL reset_br_in_buf: got %0d want 0", br);
      end
      next_cycle();
   endtask

   task automatic test_back_to_back();
      logic exp_v;
      do_reset();
      rn_if.ready = 1'b1;
      for (int k = 0; k <= 8; k++) begin
         if (k < 8) begin
            ibuf_if.valid   = 1'b1;
            ibuf_if.payload = rand_front(k, 1'b0);
         end else begin
            ibuf_if.valid = 1'b0;
         end
         @(negedge clk);
         exp_v = (k > 0);
         checks++;
         if (ibuf_if.ready !== 1'b1) begin
            failures++; $display("FAIL b2b_ibuf_ready[%0d]: got %b want 1", k, ibuf_if.ready);
         end
         checks++;
         if (rn_if.valid !== exp_v) begin
            failures++; $display("FAIL b2b_rn_valid[%0d]: got %b want %b", k, rn_if.valid, exp_v);
         end
         if (k > 0) begin
            checks++;
            if (rn_if.payload.cmt_id !== CMT_ID_W'(k - 1)) begin
               failures++;
               $display("FAIL b2b_order[%0d]: got %0d want %0d", k, rn_if.payload.cmt_id, k - 1);
            end
            checks++;
            if (occ !== OW'(1)) begin
               failures++; $display("FAIL b2b_occupancy[%0d]: got %0d want 1", k, occ);
            end
         end
         next_cycle();
      end
      rn_if.ready = 1'b0;
   endtask

   task automatic test_backpressure();
      front_t g [3];
      for (int i = 0; i < 3; i++) g[i] = rand_front(10 + i, 1'($urandom));
      do_reset();
      rn_if.ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         ibuf_if.valid   = 1'b1;
         ibuf_if.payload = g[k];
         @(negedge clk);
         checks++;
         if (ibuf_if.ready !== 1'b1) begin
            failures++; $display("FAIL bp_fill_ready[%0d]: got %b want 1", k, ibuf_if.ready);
         end
         next_cycle();
      end
      ibuf_if.payload = g[2];
      @(negedge clk);
      checks++;
      if (ibuf_if.ready !== 1'b0) begin
         failures++; $display("FAIL bp_full_ready: got %b want 0", ibuf_if.ready);
      end
      checks++;
      if (occ !== OW'(2)) begin
         failures++; $display("FAIL bp_full_occupancy: got %0d want 2", occ);
      end
      checks++;
      if (rn_if.payload !== g[0]) begin
         failures++; $display("FAIL bp_head_payload: got %h want %h", rn_if.payload, g[0]);
      end
      next_cycle();
      rn_if.ready = 1'b1;
      @(negedge clk);
      checks++;
      if (ibuf_if.ready !== 1'b0) begin
         failures++; $display("FAIL bp_release_ready: got %b want 0", ibuf_if.ready);
      end
      next_cycle();
      @(negedge clk);
      checks++;
      if (ibuf_if.ready !== 1'b1) begin
         failures++; $display("FAIL bp_next_ready: got %b want 1", ibuf_if.ready);
      end
      checks++;
      if (rn_if.payload !== g[1]) begin
         failures++; $display("FAIL bp_second_payload: got %h want %h", rn_if.payload, g[1]);
      end
      next_cycle();
      ibuf_if.valid = 1'b0;
      @(negedge clk);
      checks++;
      if (rn_if.valid !== 1'b1 || rn_if.payload !== g[2]) begin
         failures++;
         $display("FAIL bp_third_payload: got v=%b %h want v=1 %h", rn_if.valid, rn_if.payload, g[2]);
      end
      next_cycle();
      @(negedge clk);
      checks++;
      if (rn_if.valid !== 1'b0) begin
         failures++; $display("FAIL bp_drained: got %b want 0", rn_if.valid);
      end
      next_cycle();
      rn_if.ready = 1'b0;
   endtask

   task automatic test_full_simul();
      front_t g [3];
      for (int i = 0; i < 3; i++) g[i] = rand_front(20 + i, 1'b0);
      do_reset();
      rn_if.ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         ibuf_if.valid   = 1'b1;
         ibuf_if.payload = g[k];
         next_cycle();
      end
      ibuf_if.payload = g[2];
      rn_if.ready     = 1'b1;
      @(negedge clk);
      checks++;
      if (occ !== OW'(2) || ibuf_if.ready !== 1'b0) begin
         failures++; $display("FAIL fs_before: got occ=%0d rdy=%b want occ=2 rdy=0", occ, ibuf_if.ready);
      end
      next_cycle();
      ibuf_if.valid = 1'b0;
      @(negedge clk);
      checks++;
      if (occ !== OW'(1)) begin
         failures++; $display("FAIL fs_after_occupancy: got %0d want 1", occ);
      end
      checks++;
      if (rn_if.payload !== g[1]) begin
         failures++; $display("FAIL fs_after_payload: got %h want %h", rn_if.payload, g[1]);
      end
      next_cycle();
      @(negedge clk);
      checks++;
      if (rn_if.valid !== 1'b0 || occ !== OW'(0)) begin
         failures++; $display("FAIL fs_no_enq: got v=%b occ=%0d want v=0 occ=0", rn_if.valid, occ);
      end
      next_cycle();
      rn_if.ready = 1'b0;
   endtask

   task automatic test_flush();
      do_reset();
      rn_if.ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         ibuf_if.valid   = 1'b1;
         ibuf_if.payload = rand_front(30 + k, 1'b1);
         next_cycle();
      end
      ibuf_if.payload = rand_front(32, 1'b1);
      flush           = 1'b1;
      @(negedge clk);
      checks++;
      if (br !== OW'(2)) begin
         failures++; $display("FAIL flush_br_before: got %0d want 2", br);
      end
      checks++;
      if (rn_if.valid !== 1'b0) begin
         failures++; $display("FAIL flush_rn_valid: got %b want 0", rn_if.valid);
      end
      next_cycle();
      flush         = 1'b0;
      ibuf_if.valid = 1'b0;
      rn_if.ready   = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (occ !== OW'(0) || br !== OW'(0) || rn_if.valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_after[%0d]: got occ=%0d br=%0d v=%b want 0 0 0", k, occ, br,
                     rn_if.valid);
         end
         next_cycle();
      end
      rn_if.ready = 1'b0;
   endtask

   task automatic test_random_wrap();
      front_t q[$];
      front_t prev_pl;
      logic   prev_stall = 1'b0;
      logic   exp_v, do_enq, do_deq;
      int     sent = 0;
      int     cyc  = 0;
      do_reset();
      while ((sent < 100 || q.size() != 0) && cyc < 3000) begin
         ibuf_if.valid   = (sent < 100) && ($urandom_range(3) != 0);
         ibuf_if.payload = rand_front(sent, 1'($urandom));
         rn_if.ready     = ($urandom_range(2) != 0);
         flush           = ($urandom_range(49) == 0);
         @(negedge clk);
         exp_v = (q.size() != 0) && !flush;
         checks++;
         if (rn_if.valid !== exp_v) begin
            failures++; $display("FAIL rnd_rn_valid@%0d: got %b want %b", cyc, rn_if.valid, exp_v);
         end
         if (exp_v) begin
            checks++;
            if (rn_if.payload !== q[0]) begin
               failures++; $display("FAIL rnd_payload@%0d: got %h want %h", cyc, rn_if.payload, q[0]);
            end
         end
         if (prev_stall && rn_if.valid) begin
            checks++;
            if (rn_if.payload !== prev_pl) begin
               failures++;
               $display("FAIL rnd_stable@%0d: got %h want %h", cyc, rn_if.payload, prev_pl);
            end
         end
         checks++;
         if (ibuf_if.ready !== (q.size() < DEPTH)) begin
            failures++; $display("FAIL rnd_ibuf_ready@%0d: got %b want %b", cyc, ibuf_if.ready,
                                 q.size() < DEPTH);
         end
         checks++;
         if (occ !== OW'(q.size())) begin
            failures++; $display("FAIL rnd_occupancy@%0d: got %0d want %0d", cyc, occ, q.size());
         end
         checks++;
         if (br !== OW'(br_count(q)) || br > occ) begin
            failures++; $display("FAIL rnd_br_in_buf@%0d: got %0d want %0d", cyc, br, br_count(q));
         end
         do_enq     = ibuf_if.valid && (q.size() < DEPTH) && !flush;
         do_deq     = exp_v && rn_if.ready;
         if (ibuf_if.valid && q.size() < DEPTH) sent++;
         prev_stall = exp_v && !rn_if.ready;
         prev_pl    = rn_if.payload;
         next_cycle();
         if (flush) begin
            q.delete();
         end else begin
            if (do_deq) void'(q.pop_front());
            if (do_enq) q.push_back(ibuf_if.payload);
         end
         cyc++;
      end
      flush         = 1'b0;
      ibuf_if.valid = 1'b0;
      rn_if.ready   = 1'b0;
      checks++;
      if (cyc >= 3000) begin
         failures++; $display("FAIL rnd_timeout: got %0d cycles want < 3000", cyc);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      rn_if.ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         ibuf_if.valid   = 1'b1;
         ibuf_if.payload = rand_front(40 + k, 1'b1);
         next_cycle();
      end
      ibuf_if.valid = 1'b0;
      reset         = 1'b1;
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (rn_if.valid !== 1'b0 || occ !== OW'(0) || ibuf_if.ready !== 1'b1 || br !== OW'(0)) begin
         failures++;
         $display("FAIL mid_reset: got v=%b occ=%0d rdy=%b br=%0d want 0 0 1 0", rn_if.valid, occ,
                  ibuf_if.ready, br);
      end
      next_cycle();
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_backpressure();
      test_full_simul();
      test_flush();
      test_random_wrap();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
